psum_acc_ctrl: RTL and testbench

- Read-modify-write accumulation controller for the partial-sum memory.
- Accepts one `col`-lane partial-sum vector per cycle from the OFIFO drain.
- For each vector, reads the stored accumulation from the dual-address psum SRAM (`sram_db`), adds lane-wise and writes the result back.
- Also serves final-result readout requests to the output path.
- Contains same-address forwarding, because `sram_db` suppresses a write whose `A_wr` equals a simultaneous `A_rd`.

---
 rtl/psum_acc_ctrl_if.sv | 39 +++
 rtl/psum_acc_ctrl.sv | 136 +++++++++++++
 tb/tb_psum_acc_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_ctrl_if.sv
// Bundle of accumulation input, readout handshake and psum SRAM signals for psum_acc_ctrl.
// master drives the upstream inputs and sram_q; slave is the controller.
interface psum_acc_ctrl_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num     = 2048
);
    localparam int aw = $clog2(num);
    localparam int dw = col * psum_bw;

    logic          in_valid;
    logic          in_first;
    logic [aw-1:0] in_addr;
    logic [dw-1:0] in_data;
    logic          rd_req;
    logic [aw-1:0] rd_addr;
    logic          rd_ready;
    logic          out_valid;
    logic [dw-1:0] out_data;
    logic          sram_cen;
    logic          sram_ren;
    logic          sram_wen;
    logic [aw-1:0] sram_a_rd;
    logic [aw-1:0] sram_a_wr;
    logic [dw-1:0] sram_d;
    logic [dw-1:0] sram_q;

    modport master (
        output in_valid, in_first, in_addr, in_data, rd_req, rd_addr, sram_q,
        input  rd_ready, out_valid, out_data, sram_cen, sram_ren, sram_wen,
               sram_a_rd, sram_a_wr, sram_d
    );

    modport slave (
        input  in_valid, in_first, in_addr, in_data, rd_req, rd_addr, sram_q,
        output rd_ready, out_valid, out_data, sram_cen, sram_ren, sram_wen,
               sram_a_rd, sram_a_wr, sram_d
    );
endinterface

// File: rtl/psum_acc_ctrl.sv
// Two-stage read-modify-write accumulator for the psum SRAM, with same-address forwarding and readout.
// Optional macro PSUM_RELU_EN: clamp negative lanes to zero on the readout path only.
module psum_acc_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num     = 2048
) (
    input  logic          clk,
    input  logic          reset,
    psum_acc_ctrl_if.slave bus
);
    localparam int aw = $clog2(num);
    localparam int dw = col * psum_bw;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_first_q, s1_first_d;
    logic          s1_fwd_q, s1_fwd_d;
    logic          s1_rd_q, s1_rd_d;
    logic [aw-1:0] s1_addr_q, s1_addr_d;
    logic [dw-1:0] s1_data_q, s1_data_d;
    logic [dw-1:0] s1_fwdval_q, s1_fwdval_d;

    logic [dw-1:0] sum;
    logic [dw-1:0] out_lanes;
    logic [psum_bw-1:0] base;
    logic          s1_wr, acc_hit, rd_hit, rd_acc;
    logic          ren, wen;
    logic [aw-1:0] a_rd, a_wr;
    logic [dw-1:0] wdata;

    // Readouts carry zero data, so the same adder yields the read/forwarded value.
    always_comb begin
        sum       = '0;
        out_lanes = '0;
        base      = '0;
        for (int k = 0; k < col; k++) begin
            if (s1_first_q)
                base = '0;
            else if (s1_fwd_q)
                base = s1_fwdval_q[k*psum_bw +: psum_bw];
            else
                base = bus.sram_q[k*psum_bw +: psum_bw];
            sum[k*psum_bw +: psum_bw] = base + s1_data_q[k*psum_bw +: psum_bw];
`ifdef PSUM_RELU_EN
            out_lanes[k*psum_bw +: psum_bw] =
                sum[k*psum_bw + psum_bw - 1] ? '0 : sum[k*psum_bw +: psum_bw];
`else
            out_lanes[k*psum_bw +: psum_bw] = sum[k*psum_bw +: psum_bw];
`endif
        end
    end

    assign s1_wr   = s1_valid_q && !s1_rd_q;
    assign acc_hit = s1_wr && (bus.in_addr == s1_addr_q);
    assign rd_hit  = s1_wr && (bus.rd_addr == s1_addr_q);
    assign rd_acc  = bus.rd_req && !bus.in_valid;

    always_comb begin
        s1_valid_d  = 1'b0;
        s1_first_d  = 1'b0;
        s1_fwd_d    = 1'b0;
        s1_rd_d     = 1'b0;
        s1_addr_d   = '0;
        s1_data_d   = '0;
        s1_fwdval_d = '0;
        ren         = 1'b1;
        a_rd        = '0;
        if (bus.in_valid) begin
            s1_valid_d = 1'b1;
            s1_first_d = bus.in_first;
            s1_addr_d  = bus.in_addr;
            s1_data_d  = bus.in_data;
            if (!bus.in_first) begin
                if (acc_hit) begin
                    s1_fwd_d    = 1'b1;
                    s1_fwdval_d = sum;
                end else begin
                    ren  = 1'b0;
                    a_rd = bus.in_addr;
                end
            end
        end else if (rd_acc) begin
            s1_valid_d = 1'b1;
            s1_rd_d    = 1'b1;
            s1_addr_d  = bus.rd_addr;
            if (rd_hit) begin
                s1_fwd_d    = 1'b1;
                s1_fwdval_d = sum;
            end else begin
                ren  = 1'b0;
                a_rd = bus.rd_addr;
            end
        end
        wen   = !s1_wr;
        a_wr  = s1_wr ? s1_addr_q : '0;
        wdata = s1_wr ? sum : '0;
        // Reset drops any pending write in the same cycle it is asserted.
        if (reset) begin
            ren   = 1'b1;
            wen   = 1'b1;
            a_rd  = '0;
            a_wr  = '0;
            wdata = '0;
        end
    end

    assign bus.sram_ren  = ren;
    assign bus.sram_wen  = wen;
    assign bus.sram_cen  = ren & wen;
    assign bus.sram_a_rd = a_rd;
    assign bus.sram_a_wr = a_wr;
    assign bus.sram_d    = wdata;
    assign bus.rd_ready  = !reset && rd_acc;
    assign bus.out_valid = !reset && s1_valid_q && s1_rd_q;
    assign bus.out_data  = bus.out_valid ? out_lanes : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_fwd_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_fwdval_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_fwd_q    <= s1_fwd_d;
            s1_rd_q     <= s1_rd_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_fwdval_q <= s1_fwdval_d;
        end
    end
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed per-cycle vector bench for psum_acc_ctrl with a behavioural sram_db model.
module tb_psum_acc_ctrl;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int NUM = 2048;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;

`ifdef PSUM_RELU_EN
    localparam logic [BW-1:0] WRAP_OUT = 16'h0000;
`else
    localparam logic [BW-1:0] WRAP_OUT = 16'h8000;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_acc_ctrl_if #(.col(COL), .psum_bw(BW), .num(NUM)) bus ();

    psum_acc_ctrl #(.col(COL), .psum_bw(BW), .num(NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // sram_db model: a write whose address equals a simultaneous read is suppressed.
    logic [DW-1:0] mem [NUM];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NUM; i++) mem[i] <= '0;
            bus.sram_q <= '0;
            mem_init   <= 1'b1;
        end else begin
            if (!bus.sram_cen && !bus.sram_ren)
                bus.sram_q <= mem[bus.sram_a_rd];
            if (!bus.sram_cen && !bus.sram_wen &&
                !(!bus.sram_ren && bus.sram_a_rd == bus.sram_a_wr))
                mem[bus.sram_a_wr] <= bus.sram_d;
        end
    end

    int conflicts = 0;
    always @(negedge clk)
        if (!reset && !bus.sram_ren && !bus.sram_wen && bus.sram_a_rd == bus.sram_a_wr)
            conflicts++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          iv, ifi;
        logic [AW-1:0] ia;
        logic [BW-1:0] ival;
        logic          rq;
        logic [AW-1:0] ra;
        logic          rdy, ov;
        logic [BW-1:0] out;
        logic          ren;
        logic [AW-1:0] ard;
        logic          wen;
        logic [AW-1:0] awr;
        logic [BW-1:0] d;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic iv, logic ifi, int ia, logic [BW-1:0] ival,
                                logic rq, int ra, logic rdy, logic ov, logic [BW-1:0] out,
                                logic ren, int ard, logic wen, int awr, logic [BW-1:0] d);
        vec_t v;
        v.iv = iv; v.ifi = ifi; v.ia = AW'(ia); v.ival = ival;
        v.rq = rq; v.ra = AW'(ra); v.rdy = rdy; v.ov = ov; v.out = out;
        v.ren = ren; v.ard = AW'(ard); v.wen = wen; v.awr = AW'(awr); v.d = d;
        return v;
    endfunction

    function automatic logic [DW-1:0] rep(logic [BW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.in_valid = v.iv;
        bus.in_first = v.ifi;
        bus.in_addr  = v.ia;
        bus.in_data  = rep(v.ival);
        bus.rd_req   = v.rq;
        bus.rd_addr  = v.ra;
    endtask

    task automatic check_vec(vec_t v, int idx);
        chk("rd_ready",  idx, DW'(bus.rd_ready),  DW'(v.rdy));
        chk("out_valid", idx, DW'(bus.out_valid), DW'(v.ov));
        chk("out_data",  idx, bus.out_data,       v.ov ? rep(v.out) : '0);
        chk("sram_ren",  idx, DW'(bus.sram_ren),  DW'(v.ren));
        chk("sram_a_rd", idx, DW'(bus.sram_a_rd), DW'(v.ard));
        chk("sram_wen",  idx, DW'(bus.sram_wen),  DW'(v.wen));
        chk("sram_a_wr", idx, DW'(bus.sram_a_wr), DW'(v.awr));
        chk("sram_d",    idx, bus.sram_d,         v.wen ? '0 : rep(v.d));
        chk("sram_cen",  idx, DW'(bus.sram_cen),  DW'(v.ren & v.wen));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //        iv ifi ia  ival     rq ra  rdy ov out       ren ard wen awr d
        vq.push_back(mk(1, 1, 5,  3,        0, 0,  0, 0, 0,        1, 0,  1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 0, 0,        1, 0,  0, 5,  3));
        vq.push_back(mk(1, 0, 5,  4,        0, 0,  0, 0, 0,        0, 5,  1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 0, 0,        1, 0,  0, 5,  7));
        vq.push_back(mk(0, 0, 0,  0,        1, 5,  1, 0, 0,        0, 5,  1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 1, 7,        1, 0,  1, 0,  0));
        vq.push_back(mk(1, 1, 9,  1,        0, 0,  0, 0, 0,        1, 0,  1, 0,  0));
        vq.push_back(mk(1, 0, 9,  2,        0, 0,  0, 0, 0,        1, 0,  0, 9,  1));
        vq.push_back(mk(1, 0, 9,  3,        0, 0,  0, 0, 0,        1, 0,  0, 9,  3));
        vq.push_back(mk(0, 0, 0,  0,        1, 9,  1, 0, 0,        1, 0,  0, 9,  6));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 1, 6,        1, 0,  1, 0,  0));
        vq.push_back(mk(1, 1, 12, 16'h7fff, 0, 0,  0, 0, 0,        1, 0,  1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 0, 0,        1, 0,  0, 12, 16'h7fff));
        vq.push_back(mk(1, 0, 12, 1,        0, 0,  0, 0, 0,        0, 12, 1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 0, 0,        1, 0,  0, 12, 16'h8000));
        vq.push_back(mk(0, 0, 0,  0,        1, 12, 1, 0, 0,        0, 12, 1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 1, WRAP_OUT, 1, 0,  1, 0,  0));
        vq.push_back(mk(1, 1, 20, 5,        1, 9,  0, 0, 0,        1, 0,  1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        1, 9,  1, 0, 0,        0, 9,  0, 20, 5));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 1, 6,        1, 0,  1, 0,  0));
        vq.push_back(mk(1, 0, 20, 7,        1, 20, 0, 0, 0,        0, 20, 1, 0,  0));
        vq.push_back(mk(0, 0, 0,  0,        1, 20, 1, 0, 0,        1, 0,  0, 20, 12));
        vq.push_back(mk(0, 0, 0,  0,        0, 0,  0, 1, 12,       1, 0,  1, 0,  0));

        // Reset state, with live inputs that must be ignored.
        drive(mk(1, 0, 3, 16'h1234, 1, 4, 0, 0, 0, 1, 0, 1, 0, 0));
        @(negedge clk);
        check_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), -1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk);
            check_vec(vq[i], i);
            @(posedge clk);
            #1;
        end

        // Reset mid-operation: first-write to addr 2 must never land.
        drive(mk(1, 1, 2, 16'h0055, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 1, 0, 0));
        @(negedge clk);
        check_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        @(negedge clk);
        check_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 101);
        @(posedge clk);
        #1;

        chk("mem_addr2",  2,  mem[2],  '0);
        chk("mem_addr5",  5,  mem[5],  rep(16'd7));
        chk("mem_addr9",  9,  mem[9],  rep(16'd6));
        chk("mem_addr12", 12, mem[12], rep(16'h8000));
        chk("mem_addr20", 20, mem[20], rep(16'd12));
        chk("rd_wr_same_addr", 0, DW'(conflicts), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
